// File: rtl/fir_nibble_host.sv
// fir_nibble_host: host-side adapter for a nibble-serial FIR PE chain.
// Each accepted 8-bit sample is sent as a 4-cycle nibble frame on fx/fy,
// marked by f_rdy. The 4-nibble result coming back from the last PE under
// f_vld is reassembled into 16 bits and pushed into a result FIFO. A credit
// count keeps frames in flight plus words in the FIFO at or below MAX_OUT.
//
// Optional feature macro: FIR_HOST_BIAS_EN. When it is defined, the i_bias
// port exists and is latched at accept to seed the chain on fy. When it is
// undefined, fy carries zeros.
//
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_x_data/i_x_valid/o_x_ready   8-bit sample input handshake
//   o_y_data/o_y_valid/i_y_ready   16-bit result output handshake
//   o_fx_nib, o_fy_nib, o_f_rdy    frame outputs to the first PE
//   i_fr_nib, i_f_vld              result nibbles from the last PE
//   o_err                    sticky protocol error
//   i_bias                   per-frame bias (FIR_HOST_BIAS_EN only)
//
// TX state | meaning
//   IDLE   | no frame on the chain inputs
//   N0     | f_rdy, fx = x[7:4], fy = b[3:0]
//   N1     | fx = x[3:0], fy = b[7:4]
//   N2     | fx = 0, fy = b[11:8]
//   N3     | fx = 0, fy = b[15:12]; a new accept chains straight into N0
// RX state | meaning
//   WAIT   | idle, waiting for f_vld with nibble 0
//   C1..C3 | capturing nibbles 1..3; push to the FIFO in C3
module fir_nibble_host #(
  parameter int MAX_OUT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_x_data,
  input  logic        i_x_valid,
  output logic        o_x_ready,
  output logic [15:0] o_y_data,
  output logic        o_y_valid,
  input  logic        i_y_ready,
  output logic [3:0]  o_fx_nib,
  output logic [3:0]  o_fy_nib,
  output logic        o_f_rdy,
  input  logic [3:0]  i_fr_nib,
  input  logic        i_f_vld,
`ifdef FIR_HOST_BIAS_EN
  input  logic [15:0] i_bias,
`endif
  output logic        o_err
);

  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_N0, TX_N1, TX_N2, TX_N3} tx_state_t;
  typedef enum logic [1:0] {RX_WAIT, RX_C1, RX_C2, RX_C3} rx_state_t;

  tx_state_t r_tx_state, w_tx_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [7:0]  r_x, w_x_next;
  logic [15:0] r_b, w_b_next, w_bias;
  logic        r_f_rdy, w_f_rdy_next;
  logic [3:0]  r_fx, w_fx_next, r_fy, w_fy_next;
  logic        r_live;
  logic        r_err, w_err_set;
  logic [11:0] r_acc, w_acc_next;
  logic        w_push, w_pop, w_accept, w_credit_ok;
  logic [15:0] w_push_data;
  logic [CW-1:0] r_outstanding, r_count;
  logic [CW:0]   w_in_use;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [15:0]   r_mem [MAX_OUT];

`ifdef FIR_HOST_BIAS_EN
  assign w_bias = i_bias;
`else
  assign w_bias = 16'h0000;
`endif

  // Words in the FIFO plus frames still owed by the chain never exceed
  // MAX_OUT, so a returning result always has a free FIFO slot.
  assign w_in_use    = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit_ok = w_in_use < (CW + 1)'(MAX_OUT);
  // r_live holds x_ready low during reset and releases it on the release edge.
  assign o_x_ready   = r_live && (r_tx_state == TX_IDLE || r_tx_state == TX_N3) && w_credit_ok;
  assign w_accept    = i_x_valid && o_x_ready;

  assign o_f_rdy  = r_f_rdy;
  assign o_fx_nib = r_fx;
  assign o_fy_nib = r_fy;
  assign o_err    = r_err;

  // TX next state; frame outputs are decoded from the next state so they
  // come straight out of flops.
  always_comb begin
    w_tx_next    = r_tx_state;
    w_x_next     = r_x;
    w_b_next     = r_b;
    w_f_rdy_next = 1'b0;
    w_fx_next    = 4'h0;
    w_fy_next    = 4'h0;
    if (w_accept) begin
      w_x_next = i_x_data;
      w_b_next = w_bias;
    end
    case (r_tx_state)
      TX_IDLE: if (w_accept) w_tx_next = TX_N0;
      TX_N0:   w_tx_next = TX_N1;
      TX_N1:   w_tx_next = TX_N2;
      TX_N2:   w_tx_next = TX_N3;
      TX_N3:   w_tx_next = w_accept ? TX_N0 : TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
    case (w_tx_next)
      TX_N0: begin
        w_f_rdy_next = 1'b1;
        w_fx_next    = w_x_next[7:4];
        w_fy_next    = w_b_next[3:0];
      end
      TX_N1: begin
        w_fx_next = w_x_next[3:0];
        w_fy_next = w_b_next[7:4];
      end
      TX_N2:   w_fy_next = w_b_next[11:8];
      TX_N3:   w_fy_next = w_b_next[15:12];
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_tx_state <= TX_IDLE;
      r_x        <= 8'h00;
      r_b        <= 16'h0000;
      r_f_rdy    <= 1'b0;
      r_fx       <= 4'h0;
      r_fy       <= 4'h0;
      r_live     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_x        <= w_x_next;
      r_b        <= w_b_next;
      r_f_rdy    <= w_f_rdy_next;
      r_fx       <= w_fx_next;
      r_fy       <= w_fy_next;
      r_live     <= 1'b1;
    end
  end

  // RX: a frame start with nothing outstanding is discarded (stay in WAIT).
  always_comb begin
    w_rx_next  = r_rx_state;
    w_acc_next = r_acc;
    w_err_set  = 1'b0;
    w_push     = 1'b0;
    case (r_rx_state)
      RX_WAIT: begin
        if (i_f_vld) begin
          if (r_outstanding == '0) begin
            w_err_set = 1'b1;
          end else begin
            w_acc_next[3:0] = i_fr_nib;
            w_rx_next       = RX_C1;
          end
        end
      end
      RX_C1: begin
        w_err_set       = i_f_vld;
        w_acc_next[7:4] = i_fr_nib;
        w_rx_next       = RX_C2;
      end
      RX_C2: begin
        w_err_set        = i_f_vld;
        w_acc_next[11:8] = i_fr_nib;
        w_rx_next        = RX_C3;
      end
      RX_C3: begin
        w_err_set = i_f_vld;
        w_push    = 1'b1;
        w_rx_next = RX_WAIT;
      end
      default: w_rx_next = RX_WAIT;
    endcase
  end

  assign w_push_data = {i_fr_nib, r_acc};
  assign o_y_valid   = (r_count != '0);
  assign o_y_data    = o_y_valid ? r_mem[r_rptr] : 16'h0000;
  assign w_pop       = o_y_valid && i_y_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rx_state    <= RX_WAIT;
      r_acc         <= 12'h000;
      r_err         <= 1'b0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      r_acc      <= w_acc_next;
      r_err      <= r_err | w_err_set;
      case ({w_accept, w_push})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: ;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

endmodule

// File: tb/tb_fir_nibble_host.sv
module tb_fir_nibble_host;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  x_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;
  logic [3:0]  fx_nib, fy_nib, fr_nib;
  logic        f_rdy, f_vld, err;
  logic [15:0] bias_v;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fir_nibble_host #(.MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_x_data(x_data),
    .i_x_valid(x_valid),
    .o_x_ready(x_ready),
    .o_y_data(y_data),
    .o_y_valid(y_valid),
    .i_y_ready(y_ready),
    .o_fx_nib(fx_nib),
    .o_fy_nib(fy_nib),
    .o_f_rdy(f_rdy),
    .i_fr_nib(fr_nib),
    .i_f_vld(f_vld),
`ifdef FIR_HOST_BIAS_EN
    .i_bias(bias_v),
`endif
    .o_err(err)
  );

  // Reference: a frame step k carries the high then low sample nibble on X,
  // and bias nibbles LS-first on Y.
  function automatic logic [3:0] ref_fx(input logic [7:0] x, input int k);
    if (k == 0) return x[7:4];
    if (k == 1) return x[3:0];
    return 4'h0;
  endfunction

  function automatic logic [15:0] ref_bias(input logic [15:0] b);
`ifdef FIR_HOST_BIAS_EN
    return b;
`else
    return b & 16'h0000;
`endif
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    return 4'((w >> (4 * k)) & 16'h000F);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; x_valid = 1'b0; y_ready = 1'b0; f_vld = 1'b0; fr_nib = 4'h0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x_valid = 1'b1; x_data = 8'hFF; y_ready = 1'b0; f_vld = 1'b0; fr_nib = 4'h0;
    cyc(); cyc();
    total++; if (x_ready !== 1'b0) begin bad++; $display("FAIL rst_x_ready got=%b exp=0", x_ready); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rst_y_valid got=%b exp=0", y_valid); end
    total++; if (f_rdy !== 1'b0) begin bad++; $display("FAIL rst_f_rdy got=%b exp=0", f_rdy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (fx_nib !== 4'h0) begin bad++; $display("FAIL rst_fx got=%h exp=0", fx_nib); end
    total++; if (fy_nib !== 4'h0) begin bad++; $display("FAIL rst_fy got=%h exp=0", fy_nib); end
    total++; if (y_data !== 16'h0) begin bad++; $display("FAIL rst_y_data got=%h exp=0", y_data); end
    x_valid = 1'b0;
    reset_n = 1'b1;
    cyc();
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL rst_release_x_ready got=%b exp=1", x_ready); end
  endtask

  task automatic test_serialise();
    do_reset();
    bias_v = 16'h0000; x_data = 8'hA5; x_valid = 1'b1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL ser_ready got=%b exp=1", x_ready); end
    cyc();
    x_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (f_rdy !== (k == 0)) begin bad++; $display("FAIL ser_f_rdy k=%0d got=%b exp=%b", k, f_rdy, (k == 0)); end
      total++; if (fx_nib !== ref_fx(8'hA5, k)) begin bad++; $display("FAIL ser_fx k=%0d got=%h exp=%h", k, fx_nib, ref_fx(8'hA5, k)); end
      total++; if (fy_nib !== 4'h0) begin bad++; $display("FAIL ser_fy k=%0d got=%h exp=0", k, fy_nib); end
      cyc();
    end
    total++; if ({f_rdy, fx_nib} !== 5'h0) begin bad++; $display("FAIL ser_idle got=%h exp=0", {f_rdy, fx_nib}); end
  endtask

  // Follows test_serialise: one frame is outstanding.
  task automatic test_reassembly();
    logic [15:0] w;
    w = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      f_vld = (k == 0); fr_nib = nib(w, k);
      total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rea_early_valid k=%0d got=%b exp=0", k, y_valid); end
      cyc();
    end
    f_vld = 1'b0;
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL rea_valid got=%b exp=1", y_valid); end
    total++; if (y_data !== 16'h1234) begin bad++; $display("FAIL rea_data got=%h exp=1234", y_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rea_err got=%b exp=0", err); end
    y_ready = 1'b1; cyc(); y_ready = 1'b0;
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rea_pop got=%b exp=0", y_valid); end
  endtask

`ifdef FIR_HOST_BIAS_EN
  task automatic test_bias();
    logic [3:0] efx [4];
    logic [3:0] efy [4];
    efx = '{4'h7, 4'hF, 4'h0, 4'h0};
    efy = '{4'h2, 4'h0, 4'h1, 4'h0};
    do_reset();
    bias_v = 16'h0102; x_data = 8'h7F; x_valid = 1'b1;
    cyc();
    x_valid = 1'b0; bias_v = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      total++; if (fx_nib !== efx[k]) begin bad++; $display("FAIL bias_fx k=%0d got=%h exp=%h", k, fx_nib, efx[k]); end
      total++; if (fy_nib !== efy[k]) begin bad++; $display("FAIL bias_fy k=%0d got=%h exp=%h", k, fy_nib, efy[k]); end
      cyc();
    end
  endtask
`endif

  task automatic test_credits();
    int acc;
    int rdy_cyc [$];
    logic [15:0] words [4];
    do_reset();
    acc = 0; y_ready = 1'b0; x_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (f_rdy) rdy_cyc.push_back(c);
      x_data = 8'($urandom);
      if (x_ready) acc++;
      cyc();
    end
    x_valid = 1'b0;
    total++; if (acc !== 4) begin bad++; $display("FAIL cred_accepts got=%0d exp=4", acc); end
    total++; if (x_ready !== 1'b0) begin bad++; $display("FAIL cred_blocked got=%b exp=0", x_ready); end
    total++; if (rdy_cyc.size() !== 4) begin bad++; $display("FAIL cred_frames got=%0d exp=4", rdy_cyc.size()); end
    for (int i = 1; i < rdy_cyc.size(); i++) begin
      total++; if (rdy_cyc[i] - rdy_cyc[i-1] !== 4) begin bad++; $display("FAIL cred_b2b i=%0d got=%0d exp=4", i, rdy_cyc[i] - rdy_cyc[i-1]); end
    end
    for (int f = 0; f < 4; f++) begin
      words[f] = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        f_vld = (k == 0); fr_nib = nib(words[f], k);
        cyc();
      end
    end
    f_vld = 1'b0;
    total++; if (x_ready !== 1'b0) begin bad++; $display("FAIL cred_full_ready got=%b exp=0", x_ready); end
    total++; if (y_data !== words[0]) begin bad++; $display("FAIL cred_data0 got=%h exp=%h", y_data, words[0]); end
    y_ready = 1'b1; cyc(); y_ready = 1'b0;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL cred_reopen got=%b exp=1", x_ready); end
    for (int i = 1; i < 4; i++) begin
      total++; if ({y_valid, y_data} !== {1'b1, words[i]}) begin bad++; $display("FAIL cred_data%0d got=%h exp=%h", i, {y_valid, y_data}, {1'b1, words[i]}); end
      y_ready = 1'b1; cyc(); y_ready = 1'b0;
    end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL cred_empty got=%b exp=0", y_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL cred_err got=%b exp=0", err); end
  endtask

  task automatic test_errors();
    logic [15:0] w;
    do_reset();
    f_vld = 1'b1; fr_nib = 4'($urandom);
    cyc();
    f_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin fr_nib = 4'($urandom); cyc(); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_stray got=%b exp=1", err); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL err_stray_valid got=%b exp=0", y_valid); end

    do_reset();
    x_data = 8'($urandom); x_valid = 1'b1;
    cyc();
    x_valid = 1'b0;
    repeat (4) cyc();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", err); end
    w = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      f_vld = (k == 0) || (k == 2); fr_nib = nib(w, k);
      cyc();
    end
    f_vld = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_c2 got=%b exp=1", err); end
    total++; if ({y_valid, y_data} !== {1'b1, w}) begin bad++; $display("FAIL err_c2_word got=%h exp=%h", {y_valid, y_data}, {1'b1, w}); end
    y_ready = 1'b1; cyc(); y_ready = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    x_data = 8'h3C; x_valid = 1'b1;
    cyc();
    x_valid = 1'b0;
    cyc();
    total++; if (fx_nib !== 4'hC) begin bad++; $display("FAIL rmf_n1_fx got=%h exp=c", fx_nib); end
    reset_n = 1'b0;
    cyc();
    total++; if ({f_rdy, fx_nib, x_ready} !== 6'h0) begin bad++; $display("FAIL rmf_abort got=%h exp=0", {f_rdy, fx_nib, x_ready}); end
    reset_n = 1'b1;
    cyc();
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL rmf_release got=%b exp=1", x_ready); end
    f_vld = 1'b1; fr_nib = 4'h5;
    cyc();
    f_vld = 1'b0;
    repeat (4) cyc();
    total++; if ({err, y_valid} !== 2'b10) begin bad++; $display("FAIL rmf_late_result got=%b exp=10", {err, y_valid}); end
  endtask

  task automatic test_random();
    logic [8:0]  tx_q [$];
    logic [15:0] fifo [$];
    logic [8:0]  e;
    logic [15:0] rx_word, pw;
    int out_cnt, rx_pos;
    logic m_ready, acc, pop, push;
    do_reset();
    out_cnt = 0; rx_pos = 0; rx_word = 16'h0;
    for (int c = 0; c < 600; c++) begin
      e = (tx_q.size() != 0) ? tx_q.pop_front() : 9'h0;
      total++; if ({f_rdy, fx_nib, fy_nib} !== e) begin bad++; $display("FAIL rnd_tx c=%0d got=%h exp=%h", c, {f_rdy, fx_nib, fy_nib}, e); end
      m_ready = (tx_q.size() == 0) && (out_cnt + fifo.size() < MAX_OUT);
      total++; if (x_ready !== m_ready) begin bad++; $display("FAIL rnd_x_ready c=%0d got=%b exp=%b", c, x_ready, m_ready); end
      total++; if (y_valid !== (fifo.size() != 0)) begin bad++; $display("FAIL rnd_y_valid c=%0d got=%b exp=%b", c, y_valid, (fifo.size() != 0)); end
      if (fifo.size() != 0) begin
        total++; if (y_data !== fifo[0]) begin bad++; $display("FAIL rnd_y_data c=%0d got=%h exp=%h", c, y_data, fifo[0]); end
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=0", c, err); end

      x_valid = ($urandom_range(0, 3) != 0);
      x_data  = 8'($urandom);
      bias_v  = 16'($urandom);
      y_ready = ($urandom_range(0, 2) == 0);
      push = 1'b0;
      if (rx_pos > 0) begin
        f_vld = 1'b0; fr_nib = nib(rx_word, rx_pos);
        push = (rx_pos == 3);
        rx_pos = (rx_pos == 3) ? 0 : rx_pos + 1;
      end else if (out_cnt > 0 && $urandom_range(0, 2) == 0) begin
        rx_word = 16'($urandom);
        f_vld = 1'b1; fr_nib = nib(rx_word, 0);
        rx_pos = 1;
      end else begin
        f_vld = 1'b0; fr_nib = 4'($urandom);
      end
      acc = m_ready && x_valid;
      pop = (fifo.size() != 0) && y_ready;
      pw  = rx_word;
      cyc();
      if (pop) void'(fifo.pop_front());
      if (push) begin fifo.push_back(pw); out_cnt--; end
      if (acc) begin
        out_cnt++;
        for (int k = 0; k < 4; k++)
          tx_q.push_back({(k == 0), ref_fx(x_data, k), nib(ref_bias(bias_v), k)});
      end
    end
    x_valid = 1'b0; f_vld = 1'b0; y_ready = 1'b0;
  endtask

  initial begin
    bias_v = 16'h0000;
    x_data = 8'h00;
    test_reset();
    test_serialise();
    test_reassembly();
`ifdef FIR_HOST_BIAS_EN
    test_bias();
`endif
    test_credits();
    test_errors();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_nibble_host.md
# fir_nibble_host

Host-side adapter for the nibble-serial FIR processing-element chain. It accepts 8-bit parallel input samples, serialises each into a 4-cycle nibble frame on the chain's X/Y inputs with an `f_rdy` strobe, and collects the 4-nibble result returned by the last PE under `f_vld`. It reassembles each 16-bit result into a FIFO with a valid/ready output. A credit counter limits frames in flight so returned results never overflow the FIFO.

## Interface
- `MAX_OUT`, default 4: result FIFO depth and maximum frames in flight. Power of two, 2..16.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `x_data` in 8: input sample, two's complement.
- `x_valid` in 1: `x_data` valid.
- `x_ready` out 1: block accepts `x_data` this cycle.
- `y_data` out 16: reassembled filter result.
- `y_valid` out 1: `y_data` valid, held until accepted.
- `y_ready` in 1: downstream accepts `y_data`.
- `fx_nib` out 4: X nibble to first PE `Xin`.
- `fy_nib` out 4: Y nibble to first PE `Yin`.
- `f_rdy` out 1: frame-start strobe to first PE `Rdy`.
- `fr_nib` in 4: result nibble from last PE `Yout`.
- `f_vld` in 1: result frame-start from last PE `Vld`.
- `err` out 1: sticky protocol error.
- `bias` in 16: only with `FIR_HOST_BIAS_EN`; sampled at accept.

## Operation
- **TX FSM** states: IDLE, N0, N1, N2, N3.
  - Accept (`x_valid && x_ready`) latches `x_data` (and `bias`) and goes to N0.
  - Transitions N0→N1→N2→N3 are unconditional.
  - From N3: go to N0 on accept, else IDLE.
- **Per-state outputs** (all registered):
  - N0: `f_rdy=1`, `fx_nib=x[7:4]`, `fy_nib=b[3:0]`.
  - N1: `fx_nib=x[3:0]`, `fy_nib=b[7:4]`.
  - N2: `fx_nib=0`, `fy_nib=b[11:8]`.
  - N3: `fx_nib=0`, `fy_nib=b[15:12]`.
  - IDLE: `f_rdy`, `fx_nib` and `fy_nib` are all 0.
  - `f_rdy` is 0 in every state except N0.
- **`x_ready`** = (IDLE or N3) && `outstanding + fifo_count < MAX_OUT`.
- **RX FSM** states: WAIT, C1, C2, C3.
  - WAIT: `f_vld` captures `fr_nib` as result bits [3:0], go to C1.
  - C1, C2, C3 capture bits [7:4], [11:8], [15:12] unconditionally, least-significant nibble first.
  - On the C3 edge the assembled word is pushed to the FIFO; return to WAIT.
- **`outstanding`**:
  - +1 on accept, −1 on push.
  - Simultaneous accept and push leaves it unchanged.
  - Width is clog2(MAX_OUT)+1.
- **FIFO**:
  - Pop on `y_valid && y_ready`.
  - Simultaneous push and pop is legal; count is unchanged.
  - Credit rule guarantees no push when full.
- **`err`** sets and holds until reset on either condition:
  - `f_vld=1` in C1, C2 or C3 (ignored; capture continues).
  - `f_vld=1` in WAIT while `outstanding==0` (frame discarded, no push).
- **Arithmetic**: none beyond nibble packing; no sign extension, result is passed bit-exact.

## Timing
- **During reset** (`reset_n=0` at an edge), all of the following are 0 after that edge:
  - outputs: `x_ready`, `y_valid`, `f_rdy`, `err`, `fx_nib`, `fy_nib`, `y_data`;
  - internal: FSMs go to IDLE/WAIT, `outstanding` and FIFO are cleared.
- **After reset release**: `x_ready` is 1 in the first cycle after release.
- **TX**:
  - Accept at edge T puts N0 (`f_rdy=1`) on the outputs in cycle T+1; the frame occupies T+1..T+4.
  - Back-to-back frames are possible: an accept in N3 makes the next `f_rdy` immediately follow the frame, one frame per 4 cycles.
- **RX**:
  - `f_vld` with nibble0 in cycle R; nibbles 1–3 arrive in R+1..R+3.
  - Push at the end of R+3; `y_valid=1` in R+4 if the FIFO was empty.
- **FIFO output**: `y_data` is stable while `y_valid && !y_ready`.
- **Reset mid-frame** aborts both FSMs and discards partial data. A result frame arriving after reset sets `err` (`outstanding==0`).

## Configuration
- **`FIR_HOST_BIAS_EN`**:
  - Defined: port `bias` exists; its value at accept is the per-frame `b`, seeding the chain accumulator.
  - Undefined: no `bias` port, `b`=0, `fy_nib` is always 0.

## Test plan
- **Serialisation**: reset, then accept `x_data=0xA5`.
  - `f_rdy` is high one cycle.
  - `fx_nib` = A,5,0,0 on consecutive cycles.
  - `fy_nib` = 0,0,0,0.
- **Reassembly**: `f_vld` with `fr_nib` = 4,3,2,1 on consecutive cycles after one issued frame.
  - `y_valid` rises 4 cycles after `f_vld`, with `y_data=0x1234`.
- **Bias** (macro defined): `bias=0x0102`, `x_data=0x7F` → `fy_nib` = 2,0,1,0 alongside `fx_nib` = 7,F,0,0.
- **Credits**: `MAX_OUT=4`, `y_ready=0`, `x_valid` held high.
  - Exactly 4 accepts; `x_ready` stays 0 after the 4th.
  - After returning 4 results, then one pop, `x_ready` returns to 1.
- **Errors**:
  - `f_vld` with `outstanding==0` → `err=1`, no `y_valid`.
  - `f_vld` re-asserted during C2 → `err=1`, word still pushed.
- **Reset mid-frame**: `reset_n=0` during TX N1 → next cycle `f_rdy=0`, `fx_nib=0`, `x_ready=0`; `x_ready=1` in the first cycle after release.
